// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, holds each address for RD_LATENCY
// cycles, queues {pc, word} pairs and hands them to decode over valid/ready.
module instruction_fetch_unit #(
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [3:0]    LAST     = 4'(RD_LATENCY - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {START, WAIT, STALL} state_t;

  state_t        state;
  logic [63:0]   pc;
  logic [3:0]    cnt;
  logic [63:0]   q_pc   [FIFO_DEPTH];
  logic [31:0]   q_data [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          pop;
  logic          sample;
  logic          push;
  logic [CW-1:0] remain;
  logic [CW-1:0] count_next;
  logic [AW-1:0] rd_ptr_next;
  logic          unused_align;

  // Fetch addresses are word aligned; the low two target bits are dropped.
  assign unused_align = ^{startpc[1:0], redirect_pc[1:0]};

  assign imem_addr   = pc;
  assign full        = (count == FULL_CNT);
  assign pop         = inst_valid && inst_ready;
  assign sample      = (state == STALL) || ((state == WAIT) && (cnt == LAST));
  assign push        = sample && (!full || pop);
  assign remain      = count - CW'(pop);
  assign count_next  = remain + CW'(push);
  assign rd_ptr_next = rd_ptr + AW'(pop);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state      <= START;
      pc         <= '0;
      cnt        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      fetch_busy <= 1'b0;
    end else if (redirect_valid) begin
      state      <= WAIT;
      pc         <= {redirect_pc[63:2], 2'b00};
      cnt        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
      fetch_busy <= 1'b1;
    end else begin
      case (state)
        START: begin
          pc         <= {startpc[63:2], 2'b00};
          cnt        <= '0;
          state      <= WAIT;
          fetch_busy <= 1'b1;
        end
        WAIT: begin
          if (cnt != LAST) begin
            cnt <= cnt + 4'd1;
          end else if (push) begin
            pc  <= pc + 64'd4;
            cnt <= '0;
          end else begin
            state <= STALL;
          end
        end
        STALL: begin
          if (push) begin
            pc    <= pc + 64'd4;
            cnt   <= '0;
            state <= WAIT;
          end
        end
        default: state <= START;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      inst_valid <= (count_next != '0);
      // Head register: the word being pushed becomes head when nothing older remains.
      if (count_next != '0) begin
        if (remain == '0) begin
          inst_pc   <= pc;
          inst_data <= imem_data;
        end else begin
          inst_pc   <= q_pc[rd_ptr_next];
          inst_data <= q_data[rd_ptr_next];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (resetl && push && !redirect_valid) begin
      q_pc[wr_ptr]   <= pc;
      q_data[wr_ptr] <= imem_data;
    end
  end

  assert property (@(posedge CLK) disable iff (!resetl) pop |-> (count != '0));
  assert property (@(posedge CLK) disable iff (!resetl) push |-> (!full || pop));

endmodule
